mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline stage. Registers the three writeback candidates: ALU result, aligned load data and PC+4.
- Outputs are presented together with the 2-bit writeback select to the downstream 3:1 writeback mux (sel 0 = ALU, 1 = load, 2 = PC+4).
- Holds load instructions until the data-memory response arrives, and guarantees no stale load response is ever written back after a flush.

Parameters:
- WIDTH, 32, datapath width. Load alignment logic is defined for 32 only; any other value is illegal and is caught by an elaboration assertion.
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  kill the in-flight/incoming instruction (branch mispredict, trap)
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- in_alu_result  in  WIDTH  ALU result, also the load address
- in_pc_plus4  in  WIDTH  link value
- in_rd  in  REG_AW  destination register
- in_reg_write  in  1  instruction writes rd
- in_wb_sel  in  2  writeback select, passed through unchanged
- in_is_load  in  1  instruction is a load
- in_funct3  in  3  load size/sign
- dmem_rvalid  in  1  load response valid
- dmem_rdata  in  WIDTH  raw 32-bit memory word
- wb_valid  out  1  one-cycle pulse per retiring instruction
- wb_sel  out  2  to mux sel
- wb_alu  out  WIDTH  to mux in0
- wb_load  out  WIDTH  to mux in1
- wb_pc_plus4  out  WIDTH  to mux in2
- wb_rd  out  REG_AW
- wb_reg_write  out  1  register-file write enable

Behaviour:
- Reset:
  - While rst_n=0 at a clock edge: state<=IDLE and all registered outputs <= 0 (wb_valid, wb_sel, wb_alu, wb_load, wb_pc_plus4, wb_rd, wb_reg_write).
  - in_ready = rst_n & (state==IDLE).
  - Reset mid-load abandons the request; the memory is reset by the same reset.
- Handshake: an instruction is accepted when in_valid & in_ready & !flush. Upstream holds its data stable while in_valid & !in_ready.
- FSM states: IDLE, WAIT_LD, DRAIN.
- IDLE:
  - Accept of a non-load: next cycle wb_valid=1 with all fields registered (latency 1). State stays IDLE, so back-to-back non-loads run at 1 per cycle.
  - Accept of a load: capture fields, wb_valid stays 0, go to WAIT_LD.
  - dmem_rvalid in IDLE is ignored; an assertion flags it.
- WAIT_LD:
  - in_ready=0.
  - On dmem_rvalid: wb_load <= aligned data, wb_valid=1 next cycle, go to IDLE. Load-use latency is 1 cycle after rvalid.
  - No rvalid: hold and do not count.
- Flush:
  - In IDLE: drop any presented instruction; wb_valid=0 next cycle.
  - In WAIT_LD without rvalid: go to DRAIN.
  - In WAIT_LD with rvalid in the same cycle: discard the data, no wb_valid, go to IDLE.
- DRAIN: in_ready=0; wait for dmem_rvalid, discard it, go to IDLE. flush in DRAIN has no further effect.
- Load alignment, with off = alu_result[1:0]:
  - LB (000): sign-extend byte at rdata[8*off +: 8].
  - LBU (100): zero-extend byte at rdata[8*off +: 8].
  - LH (001): sign-extend halfword at rdata[16*off[1] +: 16]; off[0] is ignored (misalignment is trapped upstream).
  - LHU (101): zero-extend halfword at rdata[16*off[1] +: 16].
  - LW (010) and all other codes: full word.
- wb_reg_write = in_reg_write & (in_rd != 0); x0 is never written.
- wb_sel is passed through unchanged; the code 3 is not checked here.
- Outside a wb_valid pulse, data outputs hold their last values. Downstream must gate on wb_valid.

Decomposition:
- Shared package: load funct3 constants (LB/LH/LW/LBU/LHU), WB_SEL_ALU/WB_SEL_LOAD/WB_SEL_PC4 encodings (also used by the writeback mux instantiation), and the FSM state enum.
- Sub-module: load_align, a combinational block (funct3, offset, rdata -> extended data), so the same extract/extend logic can be reused elsewhere.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then release -> all wb_* outputs 0, in_ready=1 on the first cycle after release.
- Three back-to-back non-loads (alu 0x11/0x22/0x33, sel 0, rd 1/2/3) -> three consecutive wb_valid pulses carrying the same values, in_ready constantly 1.
- LB at addr 0x1003, rdata=0x80FF_FF7F, rvalid 4 cycles later -> in_ready low 4 cycles; wb_load=0xFFFF_FF80, wb_sel=1, one wb_valid pulse.
- LHU at addr 0x2002, rdata=0xBEEF_1234 -> wb_load=0x0000_BEEF. Then LW of the same word -> 0xBEEF_1234.
- Load accepted, flush 1 cycle later, rvalid 3 cycles after that, then a non-load -> no wb_valid for the load; in_ready stays 0 until the discarded rvalid; the non-load retires normally.
- JAL-type instruction (sel 2, pc_plus4=0x104, rd=0, reg_write=1) -> wb_pc_plus4=0x104, wb_reg_write=0. The same instruction with rd=5 -> wb_reg_write=1.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: load size codes, writeback-mux
// select encodings and the stage FSM states.
package mem_wb_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_LD = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load extraction: picks the byte/halfword addressed by the
// low address bits out of a 32-bit memory word and sign/zero-extends it.
module mem_wb_stage_load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_funct3,
  input  logic [1:0]       i_offset,
  input  logic [WIDTH-1:0] i_rdata,
  output logic [WIDTH-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfword select ignores offset[0]; misaligned halves never reach here.
  assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
  assign w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_data = {{(WIDTH-8){w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {{(WIDTH-8){1'b0}}, w_byte};
      F3_LH:   o_data = {{(WIDTH-16){w_half[15]}}, w_half};
      F3_LHU:  o_data = {{(WIDTH-16){1'b0}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: retires non-loads in one cycle, parks loads until
// the data-memory response, and discards responses of flushed loads.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_alu_result,
  input  logic [WIDTH-1:0]  in_pc_plus4,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic [1:0]        in_wb_sel,
  input  logic              in_is_load,
  input  logic [2:0]        in_funct3,
  input  logic              dmem_rvalid,
  input  logic [WIDTH-1:0]  dmem_rdata,
  output logic              wb_valid,
  output logic [1:0]        wb_sel,
  output logic [WIDTH-1:0]  wb_alu,
  output logic [WIDTH-1:0]  wb_load,
  output logic [WIDTH-1:0]  wb_pc_plus4,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_reg_write
);

  if (WIDTH != 32) begin : g_width_chk
    $error("mem_wb_stage: load alignment requires WIDTH == 32");
  end

  state_e r_state;
  state_e w_state_nxt;

  logic              w_accept;
  logic              w_acc_alu;
  logic              w_acc_load;
  logic              w_ld_done;
  logic [WIDTH-1:0]  w_ld_data;

  logic [WIDTH-1:0]  r_ld_alu;
  logic [WIDTH-1:0]  r_ld_pc4;
  logic [REG_AW-1:0] r_ld_rd;
  logic              r_ld_rw;
  logic [1:0]        r_ld_sel;
  logic [2:0]        r_ld_f3;

  assign in_ready   = rst_n & (r_state == ST_IDLE);
  assign w_accept   = in_valid & in_ready & ~flush;
  assign w_acc_alu  = w_accept & ~in_is_load;
  assign w_acc_load = w_accept & in_is_load;
  // A response arriving together with a flush belongs to a killed load.
  assign w_ld_done  = (r_state == ST_WAIT_LD) & dmem_rvalid & ~flush;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_acc_load) w_state_nxt = ST_WAIT_LD;
      ST_WAIT_LD: begin
        if (dmem_rvalid)  w_state_nxt = ST_IDLE;
        else if (flush)   w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN:   if (dmem_rvalid) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Load side-buffer: fields parked while the memory response is outstanding.
  always_ff @(posedge clk) begin
    if (w_acc_load) begin
      r_ld_alu <= in_alu_result;
      r_ld_pc4 <= in_pc_plus4;
      r_ld_rd  <= in_rd;
      r_ld_rw  <= in_reg_write & (in_rd != '0);
      r_ld_sel <= in_wb_sel;
      r_ld_f3  <= in_funct3;
    end
  end

  mem_wb_stage_load_align #(.WIDTH(WIDTH)) u_load_align (
    .i_funct3 (r_ld_f3),
    .i_offset (r_ld_alu[1:0]),
    .i_rdata  (dmem_rdata),
    .o_data   (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_sel       <= '0;
      wb_alu       <= '0;
      wb_load      <= '0;
      wb_pc_plus4  <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
    end else begin
      wb_valid <= w_acc_alu | w_ld_done;
      if (w_acc_alu) begin
        wb_sel       <= in_wb_sel;
        wb_alu       <= in_alu_result;
        wb_pc_plus4  <= in_pc_plus4;
        wb_rd        <= in_rd;
        wb_reg_write <= in_reg_write & (in_rd != '0);
      end else if (w_ld_done) begin
        wb_sel       <= r_ld_sel;
        wb_alu       <= r_ld_alu;
        wb_load      <= w_ld_data;
        wb_pc_plus4  <= r_ld_pc4;
        wb_rd        <= r_ld_rd;
        wb_reg_write <= r_ld_rw;
      end
    end
  end

  a_no_rvalid_in_idle : assert property (@(posedge clk) disable iff (!rst_n)
    !(dmem_rvalid && (r_state == ST_IDLE)));

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed scenarios plus randomized
// loads/non-loads/flushes against an arithmetic load-extension model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [1:0]  wb_sel;
  logic [31:0] wb_alu;
  logic [31:0] wb_load;
  logic [31:0] wb_pc_plus4;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;

  always #5 clk = ~clk;

  mem_wb_stage #(.WIDTH(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
    .in_is_load(in_is_load), .in_funct3(in_funct3),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_alu(wb_alu),
    .wb_load(wb_load), .wb_pc_plus4(wb_pc_plus4), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        rw;
    bit          is_ld;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: extract and extend with plain shifts/arithmetic.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] w);
    int unsigned off, b, h;
    off = addr % 4;
    b   = (w >> (8 * off)) & 32'hFF;
    h   = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128)   ? 32'(b) - 32'd256   : 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  // Monitor: every wb_valid pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && wb_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_wb_valid", 32'(wb_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("wb_sel", 32'(wb_sel), 32'(e.sel));
          chk("wb_alu", wb_alu, e.alu);
          chk("wb_pc_plus4", wb_pc_plus4, e.pc4);
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
          if (e.is_ld) chk("wb_load", wb_load, e.ld);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // flush_at: -1 = none; otherwise the wait-cycle index (0..dly-1) that carries flush.
  task automatic run_op(input bit ld, input logic [31:0] alu, input logic [31:0] pc4,
                        input logic [4:0] rd, input bit rw, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [31:0] word,
                        input int dly, input int flush_at);
    exp_t e;
    e.sel = sel; e.alu = alu; e.pc4 = pc4; e.rd = rd;
    e.rw = rw && (rd != 0); e.is_ld = ld;
    e.ld = model_load(f3, alu, word);
    in_valid = 1'b1; in_is_load = ld; in_alu_result = alu; in_pc_plus4 = pc4;
    in_rd = rd; in_reg_write = rw; in_wb_sel = sel; in_funct3 = f3; flush = 1'b0;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    if (!ld) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_alu_result = $urandom;
    if (ld) begin
      for (int c = 0; c < dly; c++) begin
        flush       = (c == flush_at);
        dmem_rvalid = (c == dly - 1);
        dmem_rdata  = dmem_rvalid ? word : $urandom;
        if (dmem_rvalid && flush_at < 0) sb.push_back(e);
        @(negedge clk);
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
      end
      flush = 1'b0;
      dmem_rvalid = 1'b0;
    end
  endtask

  task automatic flush_idle();
    in_valid = 1'b1; in_is_load = 1'b0; in_alu_result = $urandom; in_pc_plus4 = $urandom;
    in_rd = 5'd7; in_reg_write = 1'b1; in_wb_sel = 2'd0; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_sel", 32'(wb_sel), 32'd0);
    chk("rst_wb_alu", wb_alu, 32'd0);
    chk("rst_wb_load", wb_load, 32'd0);
    chk("rst_wb_pc_plus4", wb_pc_plus4, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("rst_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    bit          ld;
    logic [2:0]  f3;
    int          dly, fa;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_alu_result = '0; in_pc_plus4 = '0;
    in_rd = '0; in_reg_write = 1'b0; in_wb_sel = '0; in_is_load = 1'b0; in_funct3 = '0;
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();

    run_op(0, 32'h11, 32'h4,  5'd1, 1, 2'd0, 3'd0, 32'h0, 0, -1);
    run_op(0, 32'h22, 32'h8,  5'd2, 1, 2'd0, 3'd0, 32'h0, 0, -1);
    run_op(0, 32'h33, 32'hC,  5'd3, 1, 2'd0, 3'd0, 32'h0, 0, -1);
    run_op(1, 32'h1003, 32'h10, 5'd4, 1, 2'd1, 3'b000, 32'h80FF_FF7F, 4, -1);
    run_op(1, 32'h2002, 32'h14, 5'd5, 1, 2'd1, 3'b101, 32'hBEEF_1234, 2, -1);
    run_op(1, 32'h2000, 32'h18, 5'd6, 1, 2'd1, 3'b010, 32'hBEEF_1234, 1, -1);
    run_op(1, 32'h3000, 32'h1C, 5'd7, 1, 2'd1, 3'b010, 32'h1234_5678, 4, 0);
    run_op(0, 32'h44, 32'h20, 5'd8, 1, 2'd0, 3'd0, 32'h0, 0, -1);
    run_op(1, 32'h3001, 32'h24, 5'd9, 1, 2'd1, 3'b000, 32'hFFFF_FFFF, 2, 1);
    flush_idle();
    run_op(0, 32'h55, 32'h104, 5'd0, 1, 2'd2, 3'd0, 32'h0, 0, -1);
    run_op(0, 32'h55, 32'h104, 5'd5, 1, 2'd2, 3'd0, 32'h0, 0, -1);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(9) == 0) begin
        flush_idle();
      end else begin
        ld  = ($urandom_range(9) < 4);
        f3  = 3'($urandom_range(7));
        dly = $urandom_range(5, 1);
        fa  = ($urandom_range(4) == 0) ? $urandom_range(dly - 1) : -1;
        run_op(ld, $urandom, $urandom, 5'($urandom_range(31)), 1'($urandom_range(1)),
               ld ? 2'd1 : ($urandom_range(1) ? 2'd2 : 2'd0), f3, $urandom, dly, fa);
      end
    end

    // Reset while a load is outstanding abandons it.
    in_valid = 1'b1; in_is_load = 1'b1; in_alu_result = 32'h40; in_funct3 = 3'b010;
    in_rd = 5'd3; in_reg_write = 1'b1; in_wb_sel = 2'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    run_op(0, 32'h66, 32'h28, 5'd10, 1, 2'd0, 3'd0, 32'h0, 0, -1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
